cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Instruction sequencer for the 8-bit accumulator CPU. Owns PC, IR and the 2-bit
//  instruction cycle (FETCH/DECODE/EXEC_A/EXEC_B) consumed by the ALU.
//  Issues memory requests with a ready handshake and stalls the cycle while memory waits.
//  Resolves jumps from the ALU c/z flags, and detects halt and bus timeout.
// PARAMETERS
//  ADDR_W    5   address width, equal to IR operand field ir[4:0]
//  RESET_PC  0   PC value after reset
//  MAX_WAIT  15  max cycles mem_ready may stay low before bus error (1..255)
// PORTS
//  tclk       in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high
//  d_bus      in   8       shared data bus; sampled into IR at end of FETCH
//  c          in   1       ALU carry flag
//  z          in   1       ALU zero flag
//  mem_ready  in   1       memory completes current access this cycle
//  state      out  2       instruction cycle: 00 FETCH, 01 DECODE, 10 EXEC_A, 11 EXEC_B
//  instruction out 8       IR: [7:5] opcode, [4:0] operand address
//  pc         out  ADDR_W  program counter
//  mem_req    out  1       access request; mem_addr and mem_we are valid while high
//  mem_we     out  1       1 = write (ST), 0 = read
//  mem_addr   out  ADDR_W  access address
//  halted     out  1       sticky; set by self-jump or bus error
//  bus_err    out  1       sticky; set by mem_ready timeout
// BEHAVIOUR
//  Reset values: state=FETCH, instruction=8'h00, pc=RESET_PC, mem_req=0, mem_we=0,
//   mem_addr=0, halted=0, bus_err=0, wait counter=0. Asynchronous reset applies
//   mid-access: any outstanding mem_req drops at once.
//  Opcodes: 000 ADD, 001 SUB, 010 NAND, 011 SHIFT, 100 LD, 101 ST,
//   110 JMP (always), 111 JZC (taken if z|c).
//  Memory phases (mem_req=1); all other states have mem_req=0:
//   FETCH: read at pc.
//   EXEC_A: read at ir[4:0] for LD.
//   EXEC_B: read at ir[4:0] for 000-011; write (mem_we=1) at ir[4:0] for ST.
//  Handshake: a memory-phase state holds while mem_ready=0. On mem_ready=1 the state
//   advances at the next edge. Non-memory states advance every cycle. A ready that
//   arrives when mem_req=0 is ignored. ALU updates in a held EXEC_A/EXEC_B are
//   idempotent, so stalling is safe.
//  FETCH exit: instruction <= d_bus; pc <= pc+1 mod 2^ADDR_W (31 wraps to 0).
//  DECODE: single cycle. For JMP, or JZC taken (c,z sampled this cycle):
//   pc <= ir[4:0] and the next state is FETCH (EXEC skipped). If ir[4:0] == pc-1,
//   i.e. the jump targets itself, set halted. Untaken JZC also goes to FETCH.
//  Transitions: FETCH->DECODE->EXEC_A->EXEC_B->FETCH; jumps DECODE->FETCH.
//  Timeout: a counter clears on entering each memory phase and increments per
//   stalled cycle. If it reaches MAX_WAIT with mem_ready still 0: set bus_err and
//   halted, drop mem_req, and freeze state.
//  Halted: state, pc and instruction freeze and mem_req=0. Only reset clears this.
//  Simultaneous mem_ready and timeout-count hit in the same cycle: ready wins, no error.
// STRUCTURE
//  Shared package cpu_pkg: state encodings FETCH/DECODE/EXEC_A/EXEC_B and opcode
//   constants OP_ADD..OP_JZC, reused by alu and this block.
//  One sub-module: seq_wait_timer (load/clear, increment, terminal-count flag).
//  Everything else (state FSM, PC, IR, request decode) sits in this module.
// TESTING
//  1 Reset, memory ready every cycle, mem[0]=8'h83 (LD 3) -> state 0,1,2,3,0;
//    read at addr 3 in EXEC_A; pc=1 after FETCH; instruction=8'h83.
//  2 ST 5 with mem_ready low 3 cycles in EXEC_B -> mem_we=1, mem_addr=5 held 4 cycles,
//    then FETCH at pc; no bus_err.
//  3 JZC 9 with z=1 -> pc=9, FETCH follows DECODE; same with c=z=0 -> pc unchanged+1,
//    no EXEC states.
//  4 pc=31 fetch of ADD -> pc wraps to 0; JMP to own address (mem[4]=8'hC4) -> halted=1,
//    mem_req stays 0.
//  5 mem_ready held low in FETCH -> bus_err=halted=1 after MAX_WAIT=15 stall cycles;
//    ready on cycle 15 instead -> no error.
//  6 Assert reset mid EXEC_B stall -> all outputs at reset values asynchronously;
//    fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU.
// Holds the instruction-cycle encodings, the opcode constants and a helper that
// says which cycle/opcode combinations issue a memory access. Used by the ALU
// and by cpu_sequencer.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        DECODE = 2'b01,
        EXEC_A = 2'b10,
        EXEC_B = 2'b11
    } state_e;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_NAND  = 3'b010;
    localparam logic [2:0] OP_SHIFT = 3'b011;
    localparam logic [2:0] OP_LD    = 3'b100;
    localparam logic [2:0] OP_ST    = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_JZC   = 3'b111;

    // True when the given cycle of the given opcode talks to memory.
    function automatic logic is_mem_phase(state_e st, logic [2:0] op);
        logic mem;
        mem = 1'b0;
        case (st)
            FETCH:   mem = 1'b1;
            DECODE:  mem = 1'b0;
            EXEC_A:  mem = (op == OP_LD);
            EXEC_B:  mem = (op[2] == 1'b0) || (op == OP_ST);
            default: mem = 1'b0;
        endcase
        return mem;
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Memory wait timer for the sequencer.
// Counts stalled cycles of the current memory access; tc flags the cycle in which
// one more stall would reach MAX_WAIT stalled cycles.
// Ports:
//   tclk   clock, rising edge
//   reset  asynchronous, active-high
//   clear  zero the count (no access pending, or access completing)
//   inc    count one stalled cycle
//   tc     terminal count: count == MAX_WAIT-1
module seq_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic tclk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    logic [7:0] count_q;

    always_ff @(posedge tclk or posedge reset) begin
        if (reset) begin
            count_q <= 8'd0;
        end else if (clear) begin
            count_q <= 8'd0;
        end else if (inc) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign tc = (count_q == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer for the 8-bit accumulator CPU.
// Owns PC, IR and the FETCH/DECODE/EXEC_A/EXEC_B cycle, issues memory requests
// with a ready handshake, resolves jumps and detects self-jump halt and bus timeout.
// Ports:
//   tclk, reset     clock (rising) and asynchronous active-high reset
//   d_bus           data bus, loaded into IR when FETCH completes
//   c, z            ALU carry / zero flags, sampled in DECODE for JZC
//   mem_ready       memory completes the pending access this cycle
//   state           current instruction cycle
//   instruction     IR: [7:5] opcode, [4:0] operand address
//   pc              program counter
//   mem_req/we/addr registered memory request, write strobe and address
//   halted, bus_err sticky halt and timeout indications
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              tclk,
    input  logic              reset,
    input  logic [7:0]        d_bus,
    input  logic              c,
    input  logic              z,
    input  logic              mem_ready,
    output logic [1:0]        state,
    output logic [7:0]        instruction,
    output logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              halted,
    output logic              bus_err
);

    state_e              state_q, state_d;
    logic [7:0]          ir_q, ir_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                halted_q, halted_d;
    logic                bus_err_q, bus_err_d;

    logic [2:0]          op;
    logic [ADDR_W-1:0]   target;
    logic [ADDR_W-1:0]   pc_prev;
    logic                stall;
    logic                advance;
    logic                wait_tc;
    logic                jump_taken;

    assign op      = ir_q[7:5];
    assign target  = ADDR_W'(ir_q[4:0]);
    assign pc_prev = pc_q - ADDR_W'(1);
    assign stall   = req_q & ~mem_ready;
    // A memory phase only moves on when its own request was out and acknowledged;
    // this also covers the first cycle after reset, before the request is raised.
    assign advance = is_mem_phase(state_q, op) ? (req_q & mem_ready) : 1'b1;
    assign jump_taken = (op == OP_JMP) || ((op == OP_JZC) && (z | c));

    seq_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .tclk  (tclk),
        .reset (reset),
        .clear (~stall),
        .inc   (stall),
        .tc    (wait_tc)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        halted_d  = halted_q;
        bus_err_d = bus_err_q;

        if (!halted_q) begin
            // A ready in the terminal cycle wins because tc only matters on a stall.
            if (stall && wait_tc) begin
                bus_err_d = 1'b1;
                halted_d  = 1'b1;
            end else if (advance) begin
                unique case (state_q)
                    FETCH: begin
                        ir_d    = d_bus;
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = DECODE;
                    end
                    DECODE: begin
                        if (jump_taken) begin
                            pc_d    = target;
                            state_d = FETCH;
                            // pc already points past the jump, so pc-1 is its own address.
                            if (target == pc_prev) begin
                                halted_d = 1'b1;
                            end
                        end else if (op == OP_JZC) begin
                            state_d = FETCH;
                        end else begin
                            state_d = EXEC_A;
                        end
                    end
                    EXEC_A: state_d = EXEC_B;
                    EXEC_B: state_d = FETCH;
                endcase
            end
        end

        // Request outputs are registered from the next cycle's state.
        req_d  = ~halted_d && is_mem_phase(state_d, ir_d[7:5]);
        we_d   = req_d && (state_d == EXEC_B) && (ir_d[7:5] == OP_ST);
        addr_d = addr_q;
        if (req_d) begin
            addr_d = (state_d == FETCH) ? pc_d : ADDR_W'(ir_d[4:0]);
        end
    end

    always_ff @(posedge tclk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            ir_q      <= 8'h00;
            pc_q      <= ADDR_W'(RESET_PC);
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            halted_q  <= halted_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign state       = state_q;
    assign instruction = ir_q;
    assign pc          = pc_q;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign halted      = halted_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer with a small memory model.
module tb_cpu_sequencer;

    logic       tclk;
    logic       reset;
    logic [7:0] d_bus;
    logic       c;
    logic       z;
    logic       mem_ready;
    logic [1:0] state;
    logic [7:0] instruction;
    logic [4:0] pc;
    logic       mem_req;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic       halted;
    logic       bus_err;

    logic [7:0] mem [0:31];
    int         n_checks;
    int         n_fail;

    assign d_bus = mem[mem_addr];

    cpu_sequencer #(
        .ADDR_W   (5),
        .RESET_PC (0),
        .MAX_WAIT (15)
    ) dut (
        .tclk        (tclk),
        .reset       (reset),
        .d_bus       (d_bus),
        .c           (c),
        .z           (z),
        .mem_ready   (mem_ready),
        .state       (state),
        .instruction (instruction),
        .pc          (pc),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .halted      (halted),
        .bus_err     (bus_err)
    );

    initial tclk = 1'b0;
    always #5 tclk = ~tclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tclk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, " state"}, 32'(state), 32'd0);
        check_eq({tag, " instruction"}, 32'(instruction), 32'h00);
        check_eq({tag, " pc"}, 32'(pc), 32'd0);
        check_eq({tag, " mem_req"}, 32'(mem_req), 32'd0);
        check_eq({tag, " mem_we"}, 32'(mem_we), 32'd0);
        check_eq({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, " halted"}, 32'(halted), 32'd0);
        check_eq({tag, " bus_err"}, 32'(bus_err), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        mem_ready = 1'b1;
        c         = 1'b0;
        z         = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0]  = 8'h83;  // LD 3
        mem[1]  = 8'hA5;  // ST 5
        mem[2]  = 8'hE9;  // JZC 9
        mem[4]  = 8'hC4;  // JMP 4 (self)
        mem[9]  = 8'hEC;  // JZC 12
        mem[10] = 8'hDF;  // JMP 31
        mem[31] = 8'h07;  // ADD 7

        // Test 1: reset, LD 3 with memory always ready
        tick();
        check_reset_values("rst");
        reset = 1'b0;
        tick();
        check_eq("t1 fetch state", 32'(state), 32'd0);
        check_eq("t1 fetch req", 32'(mem_req), 32'd1);
        check_eq("t1 fetch addr", 32'(mem_addr), 32'd0);
        tick();
        check_eq("t1 decode state", 32'(state), 32'd1);
        check_eq("t1 ir", 32'(instruction), 32'h83);
        check_eq("t1 pc", 32'(pc), 32'd1);
        check_eq("t1 decode req", 32'(mem_req), 32'd0);
        tick();
        check_eq("t1 exec_a state", 32'(state), 32'd2);
        check_eq("t1 ld req", 32'(mem_req), 32'd1);
        check_eq("t1 ld addr", 32'(mem_addr), 32'd3);
        check_eq("t1 ld we", 32'(mem_we), 32'd0);
        tick();
        check_eq("t1 exec_b state", 32'(state), 32'd3);
        check_eq("t1 exec_b req", 32'(mem_req), 32'd0);
        tick();
        check_eq("t1 back fetch", 32'(state), 32'd0);
        check_eq("t1 next addr", 32'(mem_addr), 32'd1);

        // Test 2: ST 5 with three stalled cycles in EXEC_B
        tick();
        check_eq("t2 ir", 32'(instruction), 32'hA5);
        check_eq("t2 pc", 32'(pc), 32'd2);
        tick();
        check_eq("t2 exec_a state", 32'(state), 32'd2);
        check_eq("t2 exec_a req", 32'(mem_req), 32'd0);
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 3) mem_ready = 1'b1;
            check_eq("t2 st state", 32'(state), 32'd3);
            check_eq("t2 st req", 32'(mem_req), 32'd1);
            check_eq("t2 st we", 32'(mem_we), 32'd1);
            check_eq("t2 st addr", 32'(mem_addr), 32'd5);
        end
        tick();
        check_eq("t2 fetch state", 32'(state), 32'd0);
        check_eq("t2 fetch addr", 32'(mem_addr), 32'd2);
        check_eq("t2 fetch we", 32'(mem_we), 32'd0);
        check_eq("t2 bus_err", 32'(bus_err), 32'd0);

        // Test 3: JZC taken on z, then untaken with c=z=0
        tick();
        check_eq("t3 ir", 32'(instruction), 32'hE9);
        check_eq("t3 pc", 32'(pc), 32'd3);
        z = 1'b1;
        tick();
        check_eq("t3 taken state", 32'(state), 32'd0);
        check_eq("t3 taken pc", 32'(pc), 32'd9);
        check_eq("t3 taken addr", 32'(mem_addr), 32'd9);
        z = 1'b0;
        tick();
        check_eq("t3 untaken ir", 32'(instruction), 32'hEC);
        check_eq("t3 untaken pc", 32'(pc), 32'd10);
        tick();
        check_eq("t3 untaken state", 32'(state), 32'd0);
        check_eq("t3 untaken pc2", 32'(pc), 32'd10);
        check_eq("t3 untaken addr", 32'(mem_addr), 32'd10);

        // Test 4: JMP 31, ADD at 31 wraps pc, then self-jump halts
        tick();
        check_eq("t4 jmp ir", 32'(instruction), 32'hDF);
        tick();
        check_eq("t4 jmp pc", 32'(pc), 32'd31);
        check_eq("t4 jmp addr", 32'(mem_addr), 32'd31);
        tick();
        check_eq("t4 add ir", 32'(instruction), 32'h07);
        check_eq("t4 wrap pc", 32'(pc), 32'd0);
        tick();
        check_eq("t4 add exec_a req", 32'(mem_req), 32'd0);
        tick();
        check_eq("t4 add exec_b state", 32'(state), 32'd3);
        check_eq("t4 add exec_b req", 32'(mem_req), 32'd1);
        check_eq("t4 add exec_b addr", 32'(mem_addr), 32'd7);
        check_eq("t4 add exec_b we", 32'(mem_we), 32'd0);
        mem[0] = 8'hC4;  // JMP 4 from address 0
        tick();
        check_eq("t4 fetch0 addr", 32'(mem_addr), 32'd0);
        tick();
        check_eq("t4 jmp4 pc", 32'(pc), 32'd1);
        tick();
        check_eq("t4 not halted", 32'(halted), 32'd0);
        check_eq("t4 fetch4 addr", 32'(mem_addr), 32'd4);
        tick();
        check_eq("t4 self pc", 32'(pc), 32'd5);
        tick();
        check_eq("t4 halted", 32'(halted), 32'd1);
        check_eq("t4 halt pc", 32'(pc), 32'd4);
        check_eq("t4 halt req", 32'(mem_req), 32'd0);
        check_eq("t4 halt bus_err", 32'(bus_err), 32'd0);
        repeat (3) tick();
        check_eq("t4 frozen state", 32'(state), 32'd0);
        check_eq("t4 frozen pc", 32'(pc), 32'd4);
        check_eq("t4 frozen req", 32'(mem_req), 32'd0);

        // Test 5a: ready held low in FETCH times out after 15 stalls
        #2 reset = 1'b1;
        #1;
        check_eq("t5 async halted", 32'(halted), 32'd0);
        check_eq("t5 async pc", 32'(pc), 32'd0);
        mem_ready = 1'b0;
        mem[0]    = 8'h06;  // ADD 6
        tick();
        reset = 1'b0;
        tick();
        check_eq("t5 req up", 32'(mem_req), 32'd1);
        repeat (14) tick();
        check_eq("t5 no err yet", 32'(bus_err), 32'd0);
        check_eq("t5 still req", 32'(mem_req), 32'd1);
        tick();
        check_eq("t5 bus_err", 32'(bus_err), 32'd1);
        check_eq("t5 halted", 32'(halted), 32'd1);
        check_eq("t5 req dropped", 32'(mem_req), 32'd0);
        tick();
        check_eq("t5 frozen state", 32'(state), 32'd0);
        check_eq("t5 sticky err", 32'(bus_err), 32'd1);

        // Test 5b: ready arrives in the 15th cycle, no error
        #2 reset = 1'b1;
        #1;
        check_eq("t5b rst bus_err", 32'(bus_err), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("t5b req up", 32'(mem_req), 32'd1);
        repeat (14) tick();
        mem_ready = 1'b1;
        tick();
        check_eq("t5b state", 32'(state), 32'd1);
        check_eq("t5b bus_err", 32'(bus_err), 32'd0);
        check_eq("t5b halted", 32'(halted), 32'd0);
        check_eq("t5b ir", 32'(instruction), 32'h06);

        // Test 6: asynchronous reset during an EXEC_B stall
        tick();
        check_eq("t6 exec_a", 32'(state), 32'd2);
        mem_ready = 1'b0;
        tick();
        check_eq("t6 exec_b req", 32'(mem_req), 32'd1);
        check_eq("t6 exec_b addr", 32'(mem_addr), 32'd6);
        tick();
        check_eq("t6 held", 32'(state), 32'd3);
        #3 reset = 1'b1;
        #1;
        check_reset_values("t6 async");
        mem_ready = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check_eq("t6 restart req", 32'(mem_req), 32'd1);
        check_eq("t6 restart addr", 32'(mem_addr), 32'd0);
        tick();
        check_eq("t6 restart ir", 32'(instruction), 32'h06);
        check_eq("t6 restart pc", 32'(pc), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
